// File: rtl/gray_sequencer.sv
// gray_sequencer: steps a binary count up or down from a loaded start value
// to a programmed terminal value, presenting the count and its Gray code
// every cycle. Pause holds the count, stop aborts, done/wrap are flags.
//
// Control semantics: i_start is a request, accepted only in IDLE and only
// when i_stop is low. Completion is reported by o_done, high for exactly the
// one cycle the FSM sits in DONE. There is no back-pressure.
module gray_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_up_dn,
  input  logic [WIDTH-1:0] i_start_val,
  input  logic [WIDTH-1:0] i_term_val,
  output logic [WIDTH-1:0] o_binary_q,
  output logic [WIDTH-1:0] o_gray_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic [1:0]       o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] w_bin_next;
  logic             w_wrap_next;

  // Next-state / next-count decode; priority stop > terminal match > pause > step.
  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_wrap_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_state_next = S_RUN;
          w_bin_next   = i_start_val;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_next = S_IDLE;
        end else if (r_bin == i_term_val) begin
          w_state_next = S_DONE;
        end else if (i_pause) begin
          w_state_next = S_PAUSE;
        end else if (i_up_dn) begin
          w_bin_next  = r_bin + ONE;
          w_wrap_next = (r_bin == ALL_ONES);
        end else begin
          w_bin_next  = r_bin - ONE;
          w_wrap_next = (r_bin == '0);
        end
      end
      S_PAUSE: begin
        // No terminal check here; resuming costs one edge without a step.
        if (i_stop) begin
          w_state_next = S_IDLE;
        end else if (!i_pause) begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, count and Gray registers; Gray is derived from the next count so
  // it never lags the binary value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bin   <= w_bin_next;
      r_gray  <= w_bin_next ^ (w_bin_next >> 1);
      r_wrap  <= w_wrap_next;
    end
  end

  assign o_binary_q = r_bin;
  assign o_gray_q   = r_gray;
  assign o_busy     = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign o_done     = (r_state == S_DONE);
  assign o_wrap     = r_wrap;
  assign o_state    = r_state;

endmodule

// File: tb/tb_gray_sequencer.sv
// Bench for gray_sequencer: a cycle model pushes expected outputs to a queue
// before each edge; they are popped and compared one time unit after it.
module tb_gray_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop, pause, up_dn;
  logic [W-1:0] start_val, term_val;
  logic [W-1:0] binary_q, gray_q;
  logic         busy, done, wrap;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // expected word: {binary[3:0], gray[3:0], busy, done, wrap}
  logic [10:0] exp_q[$];

  // reference model state
  int           m_state = 0; // 0 idle, 1 run, 2 pause, 3 done
  logic [W-1:0] m_bin   = '0;
  logic         m_wrap  = 1'b0;

  gray_sequencer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_pause(pause), .i_up_dn(up_dn), .i_start_val(start_val),
    .i_term_val(term_val), .o_binary_q(binary_q), .o_gray_q(gray_q),
    .o_busy(busy), .o_done(done), .o_wrap(wrap), .o_state(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Gray code from its bitwise definition: g[i] = b[i] xor b[i+1].
  function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++) g[i] = (i == W-1) ? b[i] : (b[i] ^ b[i+1]);
    return g;
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    logic [W-1:0] nb;
    logic         nw;
    int           ns;
    nb = m_bin; nw = 1'b0; ns = m_state;
    if (rst) begin
      ns = 0; nb = '0;
    end else begin
      case (m_state)
        0: if (start && !stop) begin ns = 1; nb = start_val; end
        1: begin
          if (stop) ns = 0;
          else if (m_bin == term_val) ns = 3;
          else if (pause) ns = 2;
          else if (up_dn) begin nb = m_bin + 4'd1; nw = (m_bin == 4'd15); end
          else begin nb = m_bin - 4'd1; nw = (m_bin == 4'd0); end
        end
        2: if (stop) ns = 0; else if (!pause) ns = 1;
        default: ns = 0;
      endcase
    end
    m_state = ns; m_bin = nb; m_wrap = nw;
    exp_q.push_back({m_bin, gray_of(m_bin), (m_state == 1 || m_state == 2),
                     (m_state == 3), m_wrap});
  endtask

  // One clock: predict, clock, compare every output against the model.
  task automatic tick();
    logic [10:0] e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("binary_q", binary_q, e[10:7]);
    check("gray_q",   gray_q,   e[6:3]);
    check("busy",     busy,     e[2]);
    check("done",     done,     e[1]);
    check("wrap",     wrap,     e[0]);
  endtask

  task automatic do_start(input logic [W-1:0] sv, input logic [W-1:0] tv, input logic dir);
    start_val = sv; term_val = tv; up_dn = dir; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Tick until done is seen; returns edges counted after the start edge.
  task automatic run_to_done(input int start_cyc, input int max, output int lat);
    int n = 0;
    while (!done && n < max) begin tick(); n++; end
    if (!done) check("done_timeout", 0, 1);
    lat = cyc - start_cyc;
  endtask

  task automatic wait_bin(input logic [W-1:0] v, input int max);
    int n = 0;
    while (binary_q != v && n < max) begin tick(); n++; end
    if (binary_q != v) check("wait_bin_timeout", binary_q, v);
  endtask

  int lat_np, lat_p, c0, wraps;
  logic [W-1:0] gexp [6];

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; up_dn = 1; start_val = '0; term_val = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Up run 0 -> 5: Gray sequence and done latency (N=5 -> done after edge 6)
    gexp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    do_start(4'd0, 4'd5, 1'b1);
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      check("up_gray_seq", gray_q, gexp[k]);
      tick();
    end
    check("up_done", done, 1);
    check("up_lat", cyc - c0, 6);
    tick();
    check("up_idle_done", done, 0);
    check("up_idle_busy", busy, 0);

    // Down run 1 -> 14 crosses 0 -> 15 with one wrap pulse
    do_start(4'd1, 4'd14, 1'b0);
    wraps = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      if (wrap) begin wraps++; check("wrap_bin", binary_q, 15); check("wrap_gray", gray_q, 4'b1000); end
      tick();
    end
    check("down_wraps", wraps, 1);
    check("down_done", done, 1);
    tick();

    // Pause: reference latency without pause, then 3-cycle pause at count 3
    do_start(4'd0, 4'd7, 1'b1);
    c0 = cyc;
    run_to_done(c0, 30, lat_np);
    check("nopause_lat", lat_np, 8);
    tick();
    do_start(4'd0, 4'd7, 1'b1);
    c0 = cyc;
    wait_bin(4'd3, 10);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    pause = 1'b0;
    check("pause_hold", binary_q, 3);
    tick();
    check("pause_resume_hold", binary_q, 3);
    tick();
    check("pause_resume_step", binary_q, 4);
    run_to_done(c0, 30, lat_p);
    check("pause_lat", lat_p, lat_np + 4);
    tick();

    // Stop at count 2: count held, no done
    do_start(4'd0, 4'd9, 1'b1);
    wait_bin(4'd2, 10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_bin", binary_q, 2);
    for (int k = 0; k < 3; k++) begin tick(); check("stop_no_done", done, 0); end

    // start together with stop in IDLE: no load
    start_val = 4'd7; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_bin", binary_q, 2);
    check("startstop_busy", busy, 0);

    // start pulse during RUN: no reload
    do_start(4'd0, 4'd9, 1'b1);
    wait_bin(4'd3, 10);
    start_val = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    check("no_reload", binary_q, 4);
    run_to_done(cyc, 30, lat_p);
    tick();

    // Immediate terminal: start_val == term_val == 9
    do_start(4'd9, 4'd9, 1'b1);
    check("imm_bin", binary_q, 4'b1001);
    check("imm_gray", gray_q, 4'b1101);
    tick();
    check("imm_done", done, 1);
    check("imm_stay", binary_q, 9);
    check("imm_wrap", wrap, 0);
    tick();

    // Reset held two cycles mid-run
    do_start(4'd0, 4'd15, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_bin", binary_q, 0);
    check("rst_gray", gray_q, 0);
    check("rst_busy", busy, 0);
    tick();

    // Randomised runs: direction, pause, stop and term_val change mid-run
    for (int r = 0; r < 6; r++) begin
      do_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 40 && (busy || done); k++) begin
        pause = ($urandom_range(0, 3) == 0);
        stop  = ($urandom_range(0, 40) == 0);
        up_dn = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 10) == 0) term_val = 4'($urandom_range(0, 15));
        tick();
      end
      pause = 1'b0; stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
